// File: rtl/axi4lite_xbar_1x2.sv
// AXI4-lite 1-master / 2-slave address router.
// Slave 0 = main memory, slave 1 = device region, unmapped addresses get DECERR.
// Read and write paths run independently, each with one transaction in flight.
module axi4lite_xbar_1x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK = 32'hF800_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE = 32'hA000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK = 32'hFFFF_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_arvalid,
  input  logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arready,
  output logic                      m_rvalid,
  output logic [DATA_WIDTH-1:0]     m_rdata,
  output logic [1:0]                m_rresp,
  input  logic                      m_rready,
  input  logic                      m_awvalid,
  input  logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awready,
  input  logic                      m_wvalid,
  input  logic [DATA_WIDTH-1:0]     m_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wready,
  output logic                      m_bvalid,
  output logic [1:0]                m_bresp,
  input  logic                      m_bready,
  output logic [1:0]                s_arvalid,
  output logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic [1:0]                s_arready,
  input  logic [1:0]                s_rvalid,
  input  logic [2*DATA_WIDTH-1:0]   s_rdata,
  input  logic [3:0]                s_rresp,
  output logic [1:0]                s_rready,
  output logic [1:0]                s_awvalid,
  output logic [ADDR_WIDTH-1:0]     s_awaddr,
  input  logic [1:0]                s_awready,
  output logic [1:0]                s_wvalid,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic [1:0]                s_wready,
  input  logic [1:0]                s_bvalid,
  input  logic [3:0]                s_bresp,
  output logic [1:0]                s_bready
);

  typedef enum logic [1:0] {TGT_S0, TGT_S1, TGT_ERR} tgt_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;

  rstate_t r_state, r_next;
  wstate_t w_state, w_next;
  tgt_t    r_tgt, w_tgt;
  logic    r_sel, w_sel;
  logic    aw_done, w_done;
  logic    aw_fire, w_fire, b_fire, r_fire;

  // slave 0 wins when both windows match
  function automatic tgt_t decode(input logic [ADDR_WIDTH-1:0] addr);
    if ((addr & S0_MASK) == S0_BASE) return TGT_S0;
    else if ((addr & S1_MASK) == S1_BASE) return TGT_S1;
    else return TGT_ERR;
  endfunction

  assign r_sel    = (r_tgt == TGT_S1);
  assign w_sel    = (w_tgt == TGT_S1);
  assign s_araddr = m_araddr;
  assign s_awaddr = m_awaddr;
  assign s_wdata  = m_wdata;
  assign s_wstrb  = m_wstrb;

  // read path state and target register; target latched on leaving R_IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_tgt   <= TGT_S0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && m_arvalid) r_tgt <= decode(m_araddr);
    end
  end

  // read path next state and channel steering
  always_comb begin
    r_next    = r_state;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    s_arvalid = 2'b00;
    s_rready  = 2'b00;
    r_fire    = 1'b0;
    case (r_state)
      R_IDLE: if (m_arvalid) r_next = R_ADDR;
      R_ADDR: begin
        if (r_tgt == TGT_ERR) begin
          m_arready = 1'b1;
          r_next    = R_DATA;
        end else begin
          s_arvalid[r_sel] = 1'b1;
          m_arready        = s_arready[r_sel];
          if (s_arready[r_sel]) r_next = R_DATA;
        end
      end
      R_DATA: begin
        if (r_tgt == TGT_ERR) begin
          m_rvalid = 1'b1;
          m_rresp  = 2'b11;
        end else begin
          m_rvalid        = s_rvalid[r_sel];
          m_rdata         = r_sel ? s_rdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_rdata[DATA_WIDTH-1:0];
          m_rresp         = r_sel ? s_rresp[3:2] : s_rresp[1:0];
          s_rready[r_sel] = m_rready;
        end
        r_fire = m_rvalid && m_rready;
        if (r_fire) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // write path state, target and per-channel completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_tgt   <= TGT_S0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && m_awvalid && m_wvalid) w_tgt <= decode(m_awaddr);
      if (w_state == W_ADDR) begin
        aw_done <= aw_done | aw_fire;
        w_done  <= w_done | w_fire;
      end else if (w_state == W_RESP && b_fire) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // write path next state; AW and W advance independently until both are done
  always_comb begin
    w_next    = w_state;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    s_awvalid = 2'b00;
    s_wvalid  = 2'b00;
    s_bready  = 2'b00;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    b_fire    = 1'b0;
    case (w_state)
      W_IDLE: if (m_awvalid && m_wvalid) w_next = W_ADDR;
      W_ADDR: begin
        if (w_tgt == TGT_ERR) begin
          m_awready = 1'b1;
          m_wready  = 1'b1;
          w_next    = W_RESP;
        end else begin
          s_awvalid[w_sel] = !aw_done;
          s_wvalid[w_sel]  = !w_done;
          aw_fire          = !aw_done && s_awready[w_sel];
          w_fire           = !w_done && s_wready[w_sel];
          m_awready        = aw_fire;
          m_wready         = w_fire;
          if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (w_tgt == TGT_ERR) begin
          m_bvalid = 1'b1;
          m_bresp  = 2'b11;
        end else begin
          m_bvalid        = s_bvalid[w_sel];
          m_bresp         = w_sel ? s_bresp[3:2] : s_bresp[1:0];
          s_bready[w_sel] = m_bready;
        end
        b_fire = m_bvalid && m_bready;
        if (b_fire) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4lite_xbar_1x2.sv
// Directed bench for axi4lite_xbar_1x2: reactive slave models with programmable
// delays, master stimulus and checks in one linear initial block.
module tb_axi4lite_xbar_1x2;
  logic        clk = 1'b0;
  logic        rst;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr;
  logic [63:0] s_rdata;
  logic [3:0]  s_rresp;
  logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [3:0]  s_bresp;

  int checks = 0;
  int failures = 0;

  axi4lite_xbar_1x2 dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  // slave behaviour knobs, written only by the stimulus block
  int          ar_dly[2], r_dly[2], aw_dly[2], w_dly[2], b_dly[2];
  logic [31:0] rd_val[2];

  // slave model state
  int          ar_cnt[2], r_cnt[2], aw_cnt[2], w_cnt[2], b_cnt[2];
  logic        r_pend[2], aw_got[2], w_got[2];
  logic [31:0] got_awaddr[2], got_wdata[2];
  logic [3:0]  got_wstrb[2];

  // reactive slaves: ready after N cycles of valid, response N cycles after handshake
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        s_arready[i] <= 1'b0; s_rvalid[i] <= 1'b0; s_awready[i] <= 1'b0;
        s_wready[i] <= 1'b0;  s_bvalid[i] <= 1'b0;
        s_rdata[i*32 +: 32] <= 32'h0; s_rresp[i*2 +: 2] <= 2'b00; s_bresp[i*2 +: 2] <= 2'b00;
        ar_cnt[i] <= 0; r_cnt[i] <= 0; aw_cnt[i] <= 0; w_cnt[i] <= 0; b_cnt[i] <= 0;
        r_pend[i] <= 1'b0; aw_got[i] <= 1'b0; w_got[i] <= 1'b0;
      end else begin
        if (s_arvalid[i] && s_arready[i]) begin
          s_arready[i] <= 1'b0; ar_cnt[i] <= 0; r_pend[i] <= 1'b1; r_cnt[i] <= 0;
        end else if (s_arvalid[i]) begin
          if (ar_cnt[i] >= ar_dly[i]) s_arready[i] <= 1'b1;
          else ar_cnt[i] <= ar_cnt[i] + 1;
        end
        if (s_rvalid[i] && s_rready[i]) s_rvalid[i] <= 1'b0;
        else if (r_pend[i]) begin
          if (r_cnt[i] >= r_dly[i]) begin
            s_rvalid[i] <= 1'b1; r_pend[i] <= 1'b0;
            s_rdata[i*32 +: 32] <= rd_val[i]; s_rresp[i*2 +: 2] <= 2'b00;
          end else r_cnt[i] <= r_cnt[i] + 1;
        end
        if (s_awvalid[i] && s_awready[i]) begin
          s_awready[i] <= 1'b0; aw_cnt[i] <= 0; aw_got[i] <= 1'b1; got_awaddr[i] <= s_awaddr;
        end else if (s_awvalid[i]) begin
          if (aw_cnt[i] >= aw_dly[i]) s_awready[i] <= 1'b1;
          else aw_cnt[i] <= aw_cnt[i] + 1;
        end
        if (s_wvalid[i] && s_wready[i]) begin
          s_wready[i] <= 1'b0; w_cnt[i] <= 0; w_got[i] <= 1'b1;
          got_wdata[i] <= s_wdata; got_wstrb[i] <= s_wstrb;
        end else if (s_wvalid[i]) begin
          if (w_cnt[i] >= w_dly[i]) s_wready[i] <= 1'b1;
          else w_cnt[i] <= w_cnt[i] + 1;
        end
        if (s_bvalid[i] && s_bready[i]) s_bvalid[i] <= 1'b0;
        else if (aw_got[i] && w_got[i]) begin
          if (b_cnt[i] >= b_dly[i]) begin
            s_bvalid[i] <= 1'b1; s_bresp[i*2 +: 2] <= 2'b00;
            aw_got[i] <= 1'b0; w_got[i] <= 1'b0; b_cnt[i] <= 0;
          end else b_cnt[i] <= b_cnt[i] + 1;
        end
      end
    end
  end

  // monitor: slave valid activity and master-side completions
  int          cyc = 0;
  int          ar_seen[2], aw_seen[2], w_seen[2];
  int          rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp, last_bresp;
  initial begin
    for (int i = 0; i < 2; i++) begin ar_seen[i] = 0; aw_seen[i] = 0; w_seen[i] = 0; end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (s_arvalid[i]) ar_seen[i] <= ar_seen[i] + 1;
        if (s_awvalid[i]) aw_seen[i] <= aw_seen[i] + 1;
        if (s_wvalid[i])  w_seen[i]  <= w_seen[i] + 1;
      end
      if (m_rvalid && m_rready) begin
        rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; last_rdata <= m_rdata; last_rresp <= m_rresp;
      end
      if (m_bvalid && m_bready) begin
        wr_cnt <= wr_cnt + 1; wr_cyc <= cyc; last_bresp <= m_bresp;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit w_early;

  // issue a read and/or a write, hold each valid until its handshake, wait for responses
  task automatic run_master(input string tag, input bit do_rd, input bit do_wr,
                            input logic [31:0] raddr, input logic [31:0] waddr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
    int rd0 = rd_cnt;
    int wr0 = wr_cnt;
    bit done = 1'b0;
    w_early   = 1'b0;
    m_rready  = 1'b1; m_bready = 1'b1;
    m_arvalid = do_rd; m_araddr = raddr;
    m_awvalid = do_wr; m_awaddr = waddr;
    m_wvalid  = do_wr; m_wdata = wdata; m_wstrb = wstrb;
    for (int k = 0; k < 100 && !done; k++) begin
      bit arf, awf, wf;
      arf = m_arvalid && m_arready;
      awf = m_awvalid && m_awready;
      wf  = m_wvalid && m_wready;
      step();
      if (arf) m_arvalid = 1'b0;
      if (awf) m_awvalid = 1'b0;
      if (wf)  m_wvalid  = 1'b0;
      if (!m_wvalid && m_awvalid && s_wvalid == 2'b00 && s_awvalid != 2'b00 && m_bvalid == 1'b0)
        w_early = 1'b1;
      done = (!do_rd || rd_cnt > rd0) && (!do_wr || wr_cnt > wr0) &&
             !m_arvalid && !m_awvalid && !m_wvalid;
    end
    chk({tag, "_completes"}, done, 1'b1);
    m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
  endtask

  initial begin
    int ar0_0, ar1_0, aw0_0, aw1_0, w0_0, w1_0, rd0, wr0;
    for (int i = 0; i < 2; i++) begin
      ar_dly[i] = 0; r_dly[i] = 0; aw_dly[i] = 0; w_dly[i] = 0; b_dly[i] = 0; rd_val[i] = 32'h0;
    end
    rst = 1'b1;
    m_arvalid = 0; m_araddr = 0; m_rready = 0;
    m_awvalid = 0; m_awaddr = 0; m_wvalid = 0; m_wdata = 0; m_wstrb = 0; m_bready = 0;
    repeat (3) step();
    chk("reset_master_outs", {m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready, m_bvalid, m_bresp}, 64'h0);
    chk("reset_slave_outs", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 64'h0);
    rst = 1'b0;
    step();

    // read to slave 0 with a slow arready
    ar_dly[0] = 2; r_dly[0] = 1; rd_val[0] = 32'hDEAD_BEEF;
    ar0_0 = ar_seen[0]; ar1_0 = ar_seen[1];
    m_arvalid = 1'b1; m_araddr = 32'h8000_0010; m_rready = 1'b1;
    #1;
    chk("rd0_decode_cycle_arvalid", s_arvalid, 2'b00);
    chk("rd0_decode_cycle_arready", m_arready, 1'b0);
    step();
    chk("rd0_s_arvalid", s_arvalid, 2'b01);
    chk("rd0_arready_waits_slave", m_arready, 1'b0);
    run_master("rd0", 1, 0, 32'h8000_0010, 0, 0, 0);
    chk("rd0_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd0_rresp", last_rresp, 2'b00);
    chk("rd0_s1_untouched", ar_seen[1] - ar1_0, 0);
    chk("rd0_s0_used", (ar_seen[0] - ar0_0) > 0, 1'b1);

    // write to slave 1, W accepted well before AW
    aw_dly[1] = 3; w_dly[1] = 0; b_dly[1] = 1;
    aw0_0 = aw_seen[0]; w0_0 = w_seen[0];
    run_master("wr1", 0, 1, 0, 32'hA000_03F8, 32'h0000_0041, 4'b0001);
    chk("wr1_w_before_aw_seen", w_early, 1'b1);
    chk("wr1_bresp", last_bresp, 2'b00);
    chk("wr1_awaddr", got_awaddr[1], 32'hA000_03F8);
    chk("wr1_wdata", got_wdata[1], 32'h0000_0041);
    chk("wr1_wstrb", got_wstrb[1], 4'b0001);
    chk("wr1_s0_untouched", (aw_seen[0] - aw0_0) + (w_seen[0] - w0_0), 0);
    chk("wr1_idle_after", {s_awvalid, s_wvalid, m_bvalid}, 5'b0);

    // unmapped read and write answered locally
    ar0_0 = ar_seen[0]; ar1_0 = ar_seen[1];
    m_rready = 1'b1; m_arvalid = 1'b1; m_araddr = 32'h0000_1000;
    step();
    chk("rderr_arready", m_arready, 1'b1);
    chk("rderr_no_slave_valid", s_arvalid, 2'b00);
    step();
    m_arvalid = 1'b0;
    chk("rderr_rvalid_resp_data", {m_rvalid, m_rresp, m_rdata}, {1'b1, 2'b11, 32'h0});
    rd0 = rd_cnt;
    step();
    chk("rderr_done", {m_rvalid, 32'(rd_cnt - rd0)}, {1'b0, 32'd1});
    chk("rderr_no_slave_seen", (ar_seen[0] - ar0_0) + (ar_seen[1] - ar1_0), 0);

    aw0_0 = aw_seen[0]; aw1_0 = aw_seen[1]; w0_0 = w_seen[0]; w1_0 = w_seen[1];
    m_bready = 1'b1; m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'h0000_1000;
    m_wdata = 32'h1234; m_wstrb = 4'hF;
    step();
    chk("wrerr_readies", {m_awready, m_wready}, 2'b11);
    chk("wrerr_no_slave_valid", {s_awvalid, s_wvalid}, 4'b0);
    step();
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    chk("wrerr_bvalid_bresp", {m_bvalid, m_bresp}, 3'b111);
    wr0 = wr_cnt;
    step();
    chk("wrerr_done", {m_bvalid, 32'(wr_cnt - wr0)}, {1'b0, 32'd1});
    chk("wrerr_no_slave_seen", (aw_seen[0] - aw0_0) + (aw_seen[1] - aw1_0) + (w_seen[0] - w0_0) + (w_seen[1] - w1_0), 0);

    // decode window edges
    ar_dly[0] = 0; r_dly[0] = 0; rd_val[0] = 32'h0BAD_CAFE;
    ar1_0 = ar_seen[1];
    run_master("rd_s0_top", 1, 0, 32'h87FF_FFFC, 0, 0, 0);
    chk("rd_s0_top_rdata", {last_rresp, last_rdata}, {2'b00, 32'h0BAD_CAFE});
    chk("rd_s0_top_s1_untouched", ar_seen[1] - ar1_0, 0);
    ar0_0 = ar_seen[0]; ar1_0 = ar_seen[1];
    run_master("rd_past_s0", 1, 0, 32'h8800_0000, 0, 0, 0);
    chk("rd_past_s0_resp", {last_rresp, last_rdata}, {2'b11, 32'h0});
    run_master("rd_past_s1", 1, 0, 32'hA001_0000, 0, 0, 0);
    chk("rd_past_s1_resp", last_rresp, 2'b11);
    chk("rd_past_no_slave", (ar_seen[0] - ar0_0) + (ar_seen[1] - ar1_0), 0);

    // concurrent read (slow slave 0) and write (fast slave 1)
    ar_dly[0] = 0; r_dly[0] = 10; rd_val[0] = 32'h1234_5678;
    aw_dly[1] = 0; w_dly[1] = 0; b_dly[1] = 0;
    run_master("conc", 1, 1, 32'h8000_0000, 32'hA000_0000, 32'hFEED_0001, 4'hF);
    chk("conc_rdata", {last_rresp, last_rdata}, {2'b00, 32'h1234_5678});
    chk("conc_bresp", last_bresp, 2'b00);
    chk("conc_write_first", wr_cyc < rd_cyc, 1'b1);
    chk("conc_wdata", got_wdata[1], 32'hFEED_0001);

    // master stalls rready during R_DATA
    ar_dly[0] = 0; r_dly[0] = 0; rd_val[0] = 32'hCAFE_F00D;
    m_rready = 1'b0; m_arvalid = 1'b1; m_araddr = 32'h8000_0040;
    for (int k = 0; k < 20; k++) begin
      if (m_arready) begin step(); break; end
      step();
    end
    m_arvalid = 1'b0;
    for (int k = 0; k < 20 && !m_rvalid; k++) step();
    rd0 = rd_cnt;
    chk("stall_rvalid_arrives", m_rvalid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold", {m_rvalid, m_rdata, s_rready}, {1'b1, 32'hCAFE_F00D, 2'b00});
      step();
    end
    chk("stall_no_completion", rd_cnt - rd0, 0);
    m_rready = 1'b1;
    #1;
    chk("stall_release_rready", s_rready, 2'b01);
    step();
    step();
    chk("stall_one_read", {m_rvalid, 32'(rd_cnt - rd0)}, {1'b0, 32'd1});
    chk("stall_rdata", last_rdata, 32'hCAFE_F00D);

    // reset in the middle of W_ADDR, then a fresh write
    aw_dly[0] = 5; w_dly[0] = 5;
    m_bready = 1'b1; m_awvalid = 1'b1; m_wvalid = 1'b1;
    m_awaddr = 32'h8000_0004; m_wdata = 32'hDEAD_0000; m_wstrb = 4'hF;
    step();
    chk("rstmid_in_waddr", {s_awvalid, s_wvalid}, 4'b0101);
    rst = 1'b1;
    step();
    chk("rstmid_all_quiet", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                             m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 15'h0);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    rst = 1'b0;
    step();
    chk("rstmid_idle_after", {s_awvalid, s_wvalid}, 4'b0000);
    aw_dly[0] = 1; w_dly[0] = 1; b_dly[0] = 0;
    wr0 = wr_cnt;
    run_master("post_rst_wr", 0, 1, 0, 32'h8000_0004, 32'h0000_55AA, 4'hF);
    chk("post_rst_bresp", last_bresp, 2'b00);
    chk("post_rst_one_write", wr_cnt - wr0, 1);
    chk("post_rst_awaddr", got_awaddr[0], 32'h8000_0004);
    chk("post_rst_wdata", {got_wstrb[0], got_wdata[0]}, {4'hF, 32'h0000_55AA});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4lite_xbar_1x2.md
Name: axi4lite_xbar_1x2

Overview:
- Single-master AXI4-lite address router. Sits between the core's arbitrated memory port and two slaves: slave 0 is main memory (SRAM) and slave 1 is the device region (UART/CLINT).
- Decodes each read and write address and forwards the transaction to the selected slave.
- Answers unmapped addresses locally with DECERR.
- Read and write paths are independent. Each path allows one outstanding transaction.

Parameters:
- DATA_WIDTH, 32, data bus width; wstrb is DATA_WIDTH/8 bits.
- ADDR_WIDTH, 32, address width.
- S0_BASE, 32'h8000_0000, slave 0 base address.
- S0_MASK, 32'hF800_0000, slave 0 match mask.
- S1_BASE, 32'hA000_0000, slave 1 base address.
- S1_MASK, 32'hFFFF_0000, slave 1 match mask.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_arvalid/m_araddr in 1/ADDR_WIDTH; m_arready out 1: master read address channel
- m_rvalid/m_rdata/m_rresp out 1/DATA_WIDTH/2; m_rready in 1: master read data channel
- m_awvalid/m_awaddr in 1/ADDR_WIDTH; m_awready out 1: master write address channel
- m_wvalid/m_wdata/m_wstrb in 1/DATA_WIDTH/DATA_WIDTH/8; m_wready out 1: master write data channel
- m_bvalid/m_bresp out 1/2; m_bready in 1: master write response channel
- s_arvalid out 2; s_araddr out ADDR_WIDTH (broadcast); s_arready in 2: slave read address, bit i = slave i
- s_rvalid in 2; s_rdata in 2*DATA_WIDTH; s_rresp in 4; s_rready out 2: slave read data; slice i = slave i
- s_awvalid out 2; s_awaddr out ADDR_WIDTH; s_awready in 2: slave write address
- s_wvalid out 2; s_wdata/s_wstrb out DATA_WIDTH/DATA_WIDTH/8 (broadcast); s_wready in 2: slave write data
- s_bvalid in 2; s_bresp in 4; s_bready out 2: slave write response

Behaviour:
- Decode:
  - hit0 = (addr & S0_MASK) == S0_BASE; hit1 = (addr & S1_MASK) == S1_BASE.
  - hit0 takes priority when both hit.
  - Neither hit gives target ERR.
  - The target is registered when leaving IDLE and held until the transaction completes.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: m_arready=0. When m_arvalid=1, latch the target and go to R_ADDR. This adds one decode cycle of latency.
  - R_ADDR, slave t: s_arvalid[t]=1; m_arready=s_arready[t]. On s_arready[t], go to R_DATA.
  - R_ADDR, ERR: m_arready=1 for one cycle, then go to R_DATA.
  - R_DATA, slave t: m_rvalid=s_rvalid[t]; m_rdata/m_rresp = slice t; s_rready[t]=m_rready.
  - R_DATA, ERR: m_rvalid=1, m_rresp=2'b11, m_rdata=0.
  - Leave R_DATA on m_rvalid & m_rready.
- Write FSM W_IDLE -> W_ADDR -> W_RESP -> W_IDLE:
  - W_IDLE: leave only when m_awvalid & m_wvalid. The target is decoded from m_awaddr.
  - W_ADDR: AW and W are forwarded independently to slave t. Flags aw_done and w_done set on their handshakes, and m_awready/m_wready mirror the slave readies until the matching flag is set.
  - W_ADDR exit: go to W_RESP when both flags are set, counting a handshake in the current cycle.
  - ERR target: both readies = 1 for one cycle.
  - W_RESP: m_bvalid/m_bresp come from slave t. For ERR, m_bvalid=1 and m_bresp=2'b11.
  - Leave W_RESP on m_bvalid & m_bready; flags clear.
- Handshake rules:
  - Only the selected slave's valid/ready bits are ever asserted; the others stay 0.
  - The master holds address and data stable while valid is high.
  - Valids never depend combinationally on the same channel's ready.
- Concurrency: a read and a write may be in flight at once, to the same or different slaves. No ordering between the read and write paths is enforced.
- Reset:
  - Both FSMs go to IDLE, flags clear, targets are 0.
  - All outputs valid/ready = 0; m_rresp, m_bresp and m_rdata read 0.
  - Reset mid-transaction abandons the transaction, so slaves are reset in the same cycle.
- Slave stalls: unbounded; the FSM waits.

Test Plan:
- Read 0x8000_0010, slave0 returns arready after 2 cycles and rdata 0xDEADBEEF/OKAY -> s_arvalid=2'b01, m_rdata=0xDEADBEEF, m_rresp=0; s_arvalid[1] is never asserted.
- Write 0xA000_03F8 data 0x41 wstrb 4'b0001, slave1 accepts W before AW -> W_RESP entered only after both handshakes; m_bresp=0; s_wvalid returns to 0 after the W handshake.
- Read 0x0000_1000 (unmapped) -> no slave valid asserted; m_rvalid=1, m_rresp=2'b11, m_rdata=0. Repeat for a write -> m_bresp=2'b11.
- Concurrent read 0x8000_0000 to slave0 and write 0xA000_0000 to slave1 issued in the same cycle -> both complete independently; the slave0 rvalid stall does not delay the write's bvalid.
- m_rready held 0 for 5 cycles during R_DATA -> m_rvalid and m_rdata stay stable and s_rready[0]=0 until m_rready rises; exactly one read completes.
- rst asserted during W_ADDR -> next cycle all valids/readies are 0 and the FSM is in IDLE. A fresh write to 0x8000_0004 after reset completes with OKAY.
